// File: rtl/irq_ctx_stack.sv
// irq_ctx_stack: core-side interrupt context stack.
// Latches vector-redirect requests from the interrupt controller, pushes the
// interrupted PC on a nested return-address stack, drives a one-cycle PC
// override to the vector, and restores the saved PC on return-from-interrupt.
module irq_ctx_stack #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [ADDR_W-1:0]        i_PC,
  input  logic [ADDR_W-1:0]        i_VIC_iaddr,
  input  logic                     i_VIC_PC_ctrl,
  input  logic                     i_reti,
  input  logic                     i_stall,
  output logic [ADDR_W-1:0]        o_PC_next,
  output logic                     o_PC_sel,
  output logic                     o_irq_ack,
  output logic                     o_in_isr,
  output logic [$clog2(DEPTH):0]   o_depth,
  output logic                     o_overflow,
  output logic                     o_underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int DW    = PTR_W + 1;
  localparam logic [DW-1:0] ONE     = DW'(1);
  localparam logic [DW-1:0] DEPTH_V = DW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTER = 2'd1,
    ST_LEAVE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_next_q, pc_next_d;
  logic                pc_sel_q, pc_sel_d;
  logic                irq_ack_q, irq_ack_d;
  logic                in_isr_q, in_isr_d;
  logic [DW-1:0]       depth_q, depth_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;
  logic                pend_q, pend_d;
  logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
  logic [ADDR_W-1:0]   stack_q [DEPTH];
  logic [ADDR_W-1:0]   stack_d [DEPTH];

  logic                empty;
  logic                full;
  logic [PTR_W-1:0]    push_idx;
  logic [PTR_W-1:0]    pop_idx;

  assign empty    = (depth_q == '0);
  assign full     = (depth_q == DEPTH_V);
  assign push_idx = depth_q[PTR_W-1:0];
  assign pop_idx  = PTR_W'(depth_q - ONE);

  // Next-state: pending capture, FSM transitions, stack push/pop, sticky flags.
  always_comb begin
    state_d     = state_q;
    pc_next_d   = pc_next_q;
    pc_sel_d    = 1'b0;
    irq_ack_d   = 1'b0;
    depth_d     = depth_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    stack_d     = stack_q;

    // Capture first so a pulse arriving on the accepting edge is serviced
    // directly; the acceptance path below then reads the updated slot.
    if (i_VIC_PC_ctrl) begin
      pend_d      = 1'b1;
      pend_addr_d = i_VIC_iaddr;
    end

    case (state_q)
      ST_IDLE: begin
        if (!i_stall) begin
          if (i_reti) begin
            if (!empty) begin
              pc_next_d = stack_q[pop_idx];
              depth_d   = depth_q - ONE;
              pc_sel_d  = 1'b1;
              state_d   = ST_LEAVE;
            end else begin
              underflow_d = 1'b1;
            end
          end else if (pend_d) begin
            if (!full) begin
              stack_d[push_idx] = i_PC;
              depth_d           = depth_q + ONE;
              pc_next_d         = pend_addr_d;
              pc_sel_d          = 1'b1;
              irq_ack_d         = 1'b1;
              pend_d            = 1'b0;
              state_d           = ST_ENTER;
            end else begin
              pend_d     = 1'b0;
              overflow_d = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_isr_d = (depth_d != '0);
  end

  // State and registered outputs; asynchronous reset aborts any redirect.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      pc_next_q   <= '0;
      pc_sel_q    <= 1'b0;
      irq_ack_q   <= 1'b0;
      in_isr_q    <= 1'b0;
      depth_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      stack_q     <= '{default: '0};
    end else begin
      state_q     <= state_d;
      pc_next_q   <= pc_next_d;
      pc_sel_q    <= pc_sel_d;
      irq_ack_q   <= irq_ack_d;
      in_isr_q    <= in_isr_d;
      depth_q     <= depth_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      stack_q     <= stack_d;
    end
  end

  assign o_PC_next   = pc_next_q;
  assign o_PC_sel    = pc_sel_q;
  assign o_irq_ack   = irq_ack_q;
  assign o_in_isr    = in_isr_q;
  assign o_depth     = depth_q;
  assign o_overflow  = overflow_q;
  assign o_underflow = underflow_q;

endmodule

// File: tb/tb_irq_ctx_stack.sv
// Testbench for irq_ctx_stack: directed vector table, async-reset corner,
// and randomized traffic against a queue-based reference model.
module tb_irq_ctx_stack;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int DW     = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] iaddr;
  logic              ctrl;
  logic              reti;
  logic              stall;
  logic [ADDR_W-1:0] pc_next;
  logic              pc_sel;
  logic              irq_ack;
  logic              in_isr;
  logic [DW-1:0]     depth;
  logic              ovf;
  logic              udf;

  int n_checks = 0;
  int n_fail   = 0;

  irq_ctx_stack #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_PC          (pc),
    .i_VIC_iaddr   (iaddr),
    .i_VIC_PC_ctrl (ctrl),
    .i_reti        (reti),
    .i_stall       (stall),
    .o_PC_next     (pc_next),
    .o_PC_sel      (pc_sel),
    .o_irq_ack     (irq_ack),
    .o_in_isr      (in_isr),
    .o_depth       (depth),
    .o_overflow    (ovf),
    .o_underflow   (udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        stall;
    logic        ctrl;
    logic [31:0] iaddr;
    logic        reti;
    logic [31:0] pc;
    logic        esel;
    logic        eack;
    logic [31:0] enext;
    int          edepth;
    logic        eovf;
    logic        eudf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic s, logic c, logic [31:0] a, logic r, logic [31:0] p,
                              logic esel, logic eack, logic [31:0] en, int ed,
                              logic eo, logic eu);
    vec_t v;
    v.stall = s; v.ctrl = c; v.iaddr = a; v.reti = r; v.pc = p;
    v.esel = esel; v.eack = eack; v.enext = en; v.edepth = ed;
    v.eovf = eo; v.eudf = eu;
    return v;
  endfunction

  // ---------------- reference model ----------------
  logic [31:0] m_stk[$];
  logic        m_pend, m_prev_sel, m_sel, m_ack, m_ovf, m_udf;
  logic [31:0] m_paddr, m_next;

  function automatic void model_reset();
    m_stk.delete();
    m_pend = 0; m_prev_sel = 0; m_sel = 0; m_ack = 0;
    m_ovf = 0; m_udf = 0; m_paddr = '0; m_next = '0;
  endfunction

  // One clock edge: redirects occupy one cycle in which nothing is accepted.
  function automatic void model_step(logic s, logic c, logic [31:0] a, logic r, logic [31:0] p);
    logic busy;
    busy  = m_prev_sel;
    m_sel = 0;
    m_ack = 0;
    if (c) begin
      m_pend  = 1;
      m_paddr = a;
    end
    if (!busy && !s) begin
      if (r) begin
        if (m_stk.size() > 0) begin
          m_next = m_stk.pop_back();
          m_sel  = 1;
        end else begin
          m_udf = 1;
        end
      end else if (m_pend) begin
        m_pend = 0;
        if (m_stk.size() < DEPTH) begin
          m_stk.push_back(p);
          m_next = m_paddr;
          m_sel  = 1;
          m_ack  = 1;
        end else begin
          m_ovf = 1;
        end
      end
    end
    m_prev_sel = m_sel;
  endfunction

  task automatic drive(logic s, logic c, logic [31:0] a, logic r, logic [31:0] p);
    stall = s; ctrl = c; iaddr = a; reti = r; pc = p;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, '0, 0, '0);
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    logic [31:0] idle_pc;
    drive(0, 0, '0, 0, '0);
    rst = 1'b1;
    #2;
    // reset values
    chk("rst_sel",   64'(pc_sel),  64'(0));
    chk("rst_ack",   64'(irq_ack), 64'(0));
    chk("rst_next",  64'(pc_next), 64'(0));
    chk("rst_depth", 64'(depth),   64'(0));
    chk("rst_isr",   64'(in_isr),  64'(0));
    chk("rst_ovf",   64'(ovf),     64'(0));
    chk("rst_udf",   64'(udf),     64'(0));
    do_reset();

    idle_pc = 32'h0;
    // single entry / exit
    tbl.push_back(mk(0,1,32'h8000,0,32'h100, 1,1,32'h8000,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,              0,0,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,              0,0,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,              0,0,0,1,0,0));
    tbl.push_back(mk(0,0,0,1,0,              1,0,32'h100,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,              0,0,0,0,0,0));
    // nesting to full, overflow, unwind
    tbl.push_back(mk(0,1,32'h1000,0,32'h10,  1,1,32'h1000,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,              0,0,0,1,0,0));
    tbl.push_back(mk(0,1,32'h2000,0,32'h20,  1,1,32'h2000,2,0,0));
    tbl.push_back(mk(0,0,0,0,0,              0,0,0,2,0,0));
    tbl.push_back(mk(0,1,32'h3000,0,32'h30,  1,1,32'h3000,3,0,0));
    tbl.push_back(mk(0,0,0,0,0,              0,0,0,3,0,0));
    tbl.push_back(mk(0,1,32'h4000,0,32'h40,  1,1,32'h4000,4,0,0));
    tbl.push_back(mk(0,0,0,0,0,              0,0,0,4,0,0));
    tbl.push_back(mk(0,1,32'h5000,0,32'h50,  0,0,0,4,1,0));
    tbl.push_back(mk(0,0,0,0,0,              0,0,0,4,1,0));
    tbl.push_back(mk(0,0,0,1,0,              1,0,32'h40,3,1,0));
    tbl.push_back(mk(0,0,0,0,0,              0,0,0,3,1,0));
    tbl.push_back(mk(0,0,0,1,0,              1,0,32'h30,2,1,0));
    tbl.push_back(mk(0,0,0,0,0,              0,0,0,2,1,0));
    tbl.push_back(mk(0,0,0,1,0,              1,0,32'h20,1,1,0));
    tbl.push_back(mk(0,0,0,0,0,              0,0,0,1,1,0));
    tbl.push_back(mk(0,0,0,1,0,              1,0,32'h10,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,              0,0,0,0,1,0));
    // underflow, sticky
    tbl.push_back(mk(0,0,0,1,0,              0,0,0,0,1,1));
    tbl.push_back(mk(0,0,0,0,0,              0,0,0,0,1,1));
    // stall with pending overwrite
    tbl.push_back(mk(1,1,32'h8000,0,32'h300, 0,0,0,0,1,1));
    tbl.push_back(mk(1,1,32'h9000,0,32'h300, 0,0,0,0,1,1));
    tbl.push_back(mk(0,0,0,0,32'h300,        1,1,32'h9000,1,1,1));
    tbl.push_back(mk(0,0,0,0,0,              0,0,0,1,1,1));
    tbl.push_back(mk(0,0,0,0,0,              0,0,0,1,1,1));
    // stalled return ignored, then re-presented
    tbl.push_back(mk(1,0,0,1,0,              0,0,0,1,1,1));
    tbl.push_back(mk(0,0,0,1,0,              1,0,32'h300,0,1,1));
    tbl.push_back(mk(0,0,0,0,0,              0,0,0,0,1,1));
    // tail-chain
    tbl.push_back(mk(0,1,32'hB000,0,32'h200, 1,1,32'hB000,1,1,1));
    tbl.push_back(mk(0,0,0,0,0,              0,0,0,1,1,1));
    tbl.push_back(mk(0,1,32'hA000,1,0,       1,0,32'h200,0,1,1));
    tbl.push_back(mk(0,0,0,0,32'h200,        0,0,0,0,1,1));
    tbl.push_back(mk(0,0,0,0,32'h200,        1,1,32'hA000,1,1,1));
    tbl.push_back(mk(0,0,0,0,0,              0,0,0,1,1,1));
    tbl.push_back(mk(0,0,0,1,0,              1,0,32'h200,0,1,1));
    tbl.push_back(mk(0,0,0,0,0,              0,0,0,0,1,1));
    // return during ENTER is ignored
    tbl.push_back(mk(0,1,32'hC000,0,32'h400, 1,1,32'hC000,1,1,1));
    tbl.push_back(mk(0,0,0,1,0,              0,0,0,1,1,1));
    tbl.push_back(mk(0,0,0,0,0,              0,0,0,1,1,1));
    tbl.push_back(mk(0,0,0,1,0,              1,0,32'h400,0,1,1));
    tbl.push_back(mk(0,0,0,0,0,              0,0,0,0,1,1));

    foreach (tbl[i]) begin
      drive(tbl[i].stall, tbl[i].ctrl, tbl[i].iaddr, tbl[i].reti, tbl[i].pc);
      @(posedge clk); #1;
      chk($sformatf("v%0d_sel", i),   64'(pc_sel),  64'(tbl[i].esel));
      chk($sformatf("v%0d_ack", i),   64'(irq_ack), 64'(tbl[i].eack));
      if (tbl[i].esel)
        chk($sformatf("v%0d_next", i), 64'(pc_next), 64'(tbl[i].enext));
      chk($sformatf("v%0d_depth", i), 64'(depth),   64'(tbl[i].edepth));
      chk($sformatf("v%0d_isr", i),   64'(in_isr),  64'(tbl[i].edepth != 0));
      chk($sformatf("v%0d_ovf", i),   64'(ovf),     64'(tbl[i].eovf));
      chk($sformatf("v%0d_udf", i),   64'(udf),     64'(tbl[i].eudf));
    end
    drive(0, 0, '0, 0, idle_pc);

    // async reset asserted during ENTER
    do_reset();
    drive(0, 1, 32'hD000, 0, 32'h500);
    @(posedge clk); #1;
    drive(0, 0, '0, 0, '0);
    chk("ar_enter_sel",  64'(pc_sel),  64'(1));
    chk("ar_enter_ack",  64'(irq_ack), 64'(1));
    chk("ar_enter_dep",  64'(depth),   64'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("ar_sel",   64'(pc_sel),  64'(0));
    chk("ar_ack",   64'(irq_ack), 64'(0));
    chk("ar_depth", 64'(depth),   64'(0));
    chk("ar_isr",   64'(in_isr),  64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;

    // randomized traffic against the reference model
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic s, q, r;
      logic [31:0] a, p;
      if (c != 0 && c % 600 == 0) begin
        do_reset();
        model_reset();
      end
      s = ($urandom_range(0, 99) < 20);
      q = ($urandom_range(0, 99) < 30);
      r = ($urandom_range(0, 99) < 18);
      a = $urandom;
      p = $urandom;
      drive(s, q, a, r, p);
      model_step(s, q, a, r, p);
      @(posedge clk); #1;
      chk("rnd_sel",   64'(pc_sel),  64'(m_sel));
      chk("rnd_ack",   64'(irq_ack), 64'(m_ack));
      if (m_sel) chk("rnd_next", 64'(pc_next), 64'(m_next));
      chk("rnd_depth", 64'(depth),   64'(m_stk.size()));
      chk("rnd_isr",   64'(in_isr),  64'(m_stk.size() != 0));
      chk("rnd_ovf",   64'(ovf),     64'(m_ovf));
      chk("rnd_udf",   64'(udf),     64'(m_udf));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
